data_stream_packer: RTL

DATA_STREAM_PACKER -- requirements
Module: data_stream_packer

---
 rtl/data_stream_packer_if.sv | 21 ++
 rtl/data_stream_packer.sv | 97 +++++++++
 2 files changed

// File: rtl/data_stream_packer_if.sv
// Stream bundle for data_stream_packer: 16-bit input side, 32-bit output side.
// The "slave" modport is the packer's view; "master" is the view of whatever drives it.
interface data_stream_packer_if;
  logic [15:0] s_tdata;
  logic        s_tvalid;
  logic        s_tready;
  logic [31:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready;
  logic        m_tlast;

  modport slave (
    input  s_tdata, s_tvalid, m_tready,
    output s_tready, m_tdata, m_tvalid, m_tlast
  );

  modport master (
    output s_tdata, s_tvalid, m_tready,
    input  s_tready, m_tdata, m_tvalid, m_tlast
  );
endinterface

// File: rtl/data_stream_packer.sv
// Packs pairs of 16-bit stream words into 32-bit beats (first word in the low
// half), marks every PKT_LEN-th beat with m_tlast and counts completed packets.
module data_stream_packer #(
  parameter int unsigned PKT_LEN = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  data_stream_packer_if.slave  bus,
  output logic [15:0]          pkt_cnt,
  output logic                 busy
);

  localparam int unsigned BW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(PKT_LEN - 1);

  typedef enum logic {
    EMPTY = 1'b0,
    HALF  = 1'b1
  } state_t;

  state_t        r_state;
  logic [15:0]   r_low;
  logic [31:0]   r_data;
  logic          r_valid;
  logic          r_last;
  logic [BW-1:0] r_beat;
  logic [15:0]   r_pkt_cnt;

  logic          w_s_tready;
  logic          w_in_hs;
  logic          w_out_hs;
  logic [BW-1:0] w_beat_next;

  // Handshakes and the beat index the next loaded word will carry.
  // r_beat tracks the pending word (or the next one if none is pending), so a
  // reload in the same cycle as an output handshake takes the advanced index.
  always_comb begin
    w_s_tready  = reset_n & ((r_state == EMPTY) | ~r_valid | bus.m_tready);
    w_in_hs     = bus.s_tvalid & w_s_tready;
    w_out_hs    = r_valid & bus.m_tready;
    w_beat_next = r_beat;
    if (w_out_hs) begin
      w_beat_next = (r_beat == LAST_BEAT) ? '0 : r_beat + 1'b1;
    end
  end

  // Packing FSM with registered output word, tlast, beat and packet counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= EMPTY;
      r_low     <= '0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_last    <= 1'b0;
      r_beat    <= '0;
      r_pkt_cnt <= '0;
    end else begin
      r_beat <= w_beat_next;
      if (w_out_hs && r_last) begin
        r_pkt_cnt <= r_pkt_cnt + 16'd1;
      end

      if (w_in_hs && (r_state == HALF)) begin
        r_data  <= {bus.s_tdata, r_low};
        r_valid <= 1'b1;
        r_last  <= (w_beat_next == LAST_BEAT);
      end else if (w_out_hs) begin
        r_valid <= 1'b0;
        r_last  <= 1'b0;
      end

      if (w_in_hs) begin
        case (r_state)
          EMPTY: begin
            r_low   <= bus.s_tdata;
            r_state <= HALF;
          end
          HALF: begin
            r_state <= EMPTY;
          end
          default: r_state <= EMPTY;
        endcase
      end
    end
  end

  // Output drive; registers are already zero under reset, s_tready is gated.
  always_comb begin
    bus.s_tready = w_s_tready;
    bus.m_tdata  = r_data;
    bus.m_tvalid = r_valid;
    bus.m_tlast  = r_last;
    pkt_cnt      = r_pkt_cnt;
    busy         = (r_state == HALF) | r_valid;
  end

endmodule
